// File: rtl/wb_stage_pipe.sv
// wb_stage_pipe: writeback stage between DM and the register-file write port.
// Latency: 1 cycle from accept to wb_valid; throughput 1 entry/cycle with rf_busy=0.
// Backpressure: in_ready is registered (= skid slot free); rf_busy holds M, S absorbs one more.
//
// Optional feature macro: WB_RETIRE_CNT_EN (adds retire_cnt output and its counter).
//
// Ports:
//   clk, reset               stage clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready      upstream handshake; in_ready comes straight from a flop
//   in_sel                   result source: 00 ALU, 01 DM, 10 link, 11 zero
//   in_alu, in_dm, in_link   candidate result values
//   in_wr, in_addr           register write request and destination register
//   flush                    synchronous discard of every held entry and the same-cycle input
//   rf_busy                  register-file port busy; the presented entry must hold
//   wb_valid, wb_we          output entry valid / register-file write enable (r0 suppressed)
//   wb_addr, wb_data         register-file write address / data, stable while held
//   retire_cnt               retired-entry count (WB_RETIRE_CNT_EN only)

module wb_stage_pipe #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_sel,
  input  logic [DATA_W-1:0] in_alu,
  input  logic [DATA_W-1:0] in_dm,
  input  logic [DATA_W-1:0] in_link,
  input  logic              in_wr,
  input  logic [ADDR_W-1:0] in_addr,
  input  logic              flush,
  input  logic              rf_busy,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
`ifdef WB_RETIRE_CNT_EN
  ,
  output logic [CNT_W-1:0]  retire_cnt
`endif
);

  // Source select encodings.
  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_DM   = 2'b01;
  localparam logic [1:0] SEL_LINK = 2'b10;

  // Main entry (M): the oldest entry, drives the outputs.
  logic              m_vld;
  logic              m_wr;
  logic [ADDR_W-1:0] m_addr;
  logic [DATA_W-1:0] m_data;

  // Skid entry (S): catches the one entry accepted while M is held.
  logic              s_vld;
  logic              s_wr;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data;

  // Next-state values.
  logic              m_vld_nx;
  logic              m_wr_nx;
  logic [ADDR_W-1:0] m_addr_nx;
  logic [DATA_W-1:0] m_data_nx;
  logic              s_vld_nx;
  logic              s_wr_nx;
  logic [ADDR_W-1:0] s_addr_nx;
  logic [DATA_W-1:0] s_data_nx;

  logic              rdy_q;
  logic [DATA_W-1:0] sel_data;
  logic              accept;
  logic              m_drain;

  // Result-source mux sits ahead of the registers so only the chosen value is stored.
  always_comb begin
    sel_data = '0;
    case (in_sel)
      SEL_ALU:  sel_data = in_alu;
      SEL_DM:   sel_data = in_dm;
      SEL_LINK: sel_data = in_link;
      default:  sel_data = '0;
    endcase
  end

  assign accept  = in_valid && rdy_q;
  // An empty M counts as draining so a new entry can land in it directly.
  assign m_drain = !m_vld || !rf_busy;

  always_comb begin
    m_vld_nx  = m_vld;
    m_wr_nx   = m_wr;
    m_addr_nx = m_addr;
    m_data_nx = m_data;
    s_vld_nx  = s_vld;
    s_wr_nx   = s_wr;
    s_addr_nx = s_addr;
    s_data_nx = s_data;

    if (flush) begin
      // Stored fields are left alone: outputs only need to be meaningful while valid.
      m_vld_nx = 1'b0;
      s_vld_nx = 1'b0;
    end else if (m_drain) begin
      if (s_vld) begin
        // S is older than any new input, so it moves up first.
        m_vld_nx  = 1'b1;
        m_wr_nx   = s_wr;
        m_addr_nx = s_addr;
        m_data_nx = s_data;
        s_vld_nx  = accept;
        if (accept) begin
          s_wr_nx   = in_wr;
          s_addr_nx = in_addr;
          s_data_nx = sel_data;
        end
      end else begin
        m_vld_nx = accept;
        if (accept) begin
          m_wr_nx   = in_wr;
          m_addr_nx = in_addr;
          m_data_nx = sel_data;
        end
      end
    end else if (accept) begin
      // M is held by rf_busy; in_ready was only high because S was free.
      s_vld_nx  = 1'b1;
      s_wr_nx   = in_wr;
      s_addr_nx = in_addr;
      s_data_nx = sel_data;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_vld  <= 1'b0;
      m_wr   <= 1'b0;
      m_addr <= '0;
      m_data <= '0;
      s_vld  <= 1'b0;
      s_wr   <= 1'b0;
      s_addr <= '0;
      s_data <= '0;
      rdy_q  <= 1'b1;
    end else begin
      m_vld  <= m_vld_nx;
      m_wr   <= m_wr_nx;
      m_addr <= m_addr_nx;
      m_data <= m_data_nx;
      s_vld  <= s_vld_nx;
      s_wr   <= s_wr_nx;
      s_addr <= s_addr_nx;
      s_data <= s_data_nx;
      // Ready is a flop: a free skid slot guarantees room for one more entry
      // regardless of what rf_busy does next cycle.
      rdy_q  <= !s_vld_nx;
    end
  end

  assign in_ready = rdy_q;
  assign wb_valid = m_vld;
  // r0 is hard-wired zero: the entry still retires, it just never writes.
  assign wb_we    = m_vld && m_wr && (m_addr != '0);
  assign wb_addr  = m_addr;
  assign wb_data  = m_data;

`ifdef WB_RETIRE_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts entries leaving M into the register file; wraps naturally, survives flush.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else if (m_vld && !rf_busy && !flush) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign retire_cnt = cnt_q;
`else
  // No retire counter in this build.
`endif

endmodule
